// File: rtl/cnu_min_sched.sv
// Serial min-sum check-node scheduler: running min1/min2/idx/sign per row,
// one registered result per row over a valid/ready handshake.
module cnu_min_sched #(
    parameter int DATA_W = 9,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mag,
    input  logic              in_sign,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min1,
    output logic [DATA_W-1:0] out_min2,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_sign,
    output logic [IDX_W:0]    out_deg,
    output logic              out_ovf
);
    // state | meaning
    // IDLE  | no partial row
    // ACC   | row in progress
    // HOLD  | result pending, out_valid high
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [IDX_W:0]    DEG_MAX  = {1'b1, {IDX_W{1'b0}}};
    localparam logic [DATA_W-1:0] MAG_ONES = {DATA_W{1'b1}};

    logic [1:0]        state;
    logic [DATA_W-1:0] acc_min1, acc_min2;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_sign;
    logic [IDX_W:0]    acc_cnt;

    logic [DATA_W-1:0] n_min1, n_min2;
    logic [IDX_W-1:0]  n_idx;
    logic              n_sign;
    logic [IDX_W:0]    n_cnt;
    logic              drop, take, row_done;

    assign in_ready  = (state != HOLD) || out_ready;
    assign out_valid = (state == HOLD);
    // flush never touches a pending result, so it only wins outside HOLD
    assign drop      = flush && (state != HOLD);
    assign take      = in_valid && in_ready && !drop;

    always_comb begin
        n_min1 = in_mag;
        n_min2 = MAG_ONES;
        n_idx  = '0;
        n_sign = in_sign;
        n_cnt  = (IDX_W+1)'(1);
        if (state == ACC) begin
            n_min1 = acc_min1;
            n_min2 = acc_min2;
            n_idx  = acc_idx;
            // strict compares: equal magnitudes keep the lower index
            if (in_mag < acc_min1) begin
                n_min2 = acc_min1;
                n_min1 = in_mag;
                n_idx  = acc_cnt[IDX_W-1:0];
            end else if (in_mag < acc_min2) begin
                n_min2 = in_mag;
            end
            n_sign = acc_sign ^ in_sign;
            n_cnt  = acc_cnt + (IDX_W+1)'(1);
        end
    end

    assign row_done = in_last || (n_cnt == DEG_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc_min1 <= '0;
            acc_min2 <= '0;
            acc_idx  <= '0;
            acc_sign <= 1'b0;
            acc_cnt  <= '0;
            out_min1 <= '0;
            out_min2 <= '0;
            out_idx  <= '0;
            out_sign <= 1'b0;
            out_deg  <= '0;
            out_ovf  <= 1'b0;
        end else if (drop) begin
            state    <= IDLE;
            acc_min1 <= '0;
            acc_min2 <= '0;
            acc_idx  <= '0;
            acc_sign <= 1'b0;
            acc_cnt  <= '0;
        end else if (take) begin
            if (row_done) begin
                state    <= HOLD;
                out_min1 <= n_min1;
                out_min2 <= n_min2;
                out_idx  <= n_idx;
                out_sign <= n_sign;
                out_deg  <= n_cnt;
                out_ovf  <= !in_last;
                acc_min1 <= '0;
                acc_min2 <= '0;
                acc_idx  <= '0;
                acc_sign <= 1'b0;
                acc_cnt  <= '0;
            end else begin
                state    <= ACC;
                acc_min1 <= n_min1;
                acc_min2 <= n_min2;
                acc_idx  <= n_idx;
                acc_sign <= n_sign;
                acc_cnt  <= n_cnt;
            end
        end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_cnu_min_sched.sv
// Directed bench for cnu_min_sched; expected results queued at stimulus time
// and popped by a monitor on every output handshake.
module tb_cnu_min_sched;
    localparam int DATA_W = 9;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_mag = '0;
    logic              in_sign = 1'b0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_min1, out_min2;
    logic [IDX_W-1:0]  out_idx;
    logic              out_sign;
    logic [IDX_W:0]    out_deg;
    logic              out_ovf;

    int errors = 0;
    int checks = 0;
    int issued = 0;
    int received = 0;
    logic [26:0] exp_q[$];

    cnu_min_sched #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mag(in_mag), .in_sign(in_sign), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min1(out_min1), .out_min2(out_min2), .out_idx(out_idx),
        .out_sign(out_sign), .out_deg(out_deg), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] pack(input int m1, input int m2, input int idx,
                                         input int sgn, input int deg, input int ovf);
        return {9'(m1), 9'(m2), 3'(idx), 1'(sgn), 4'(deg), 1'(ovf)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_row(input int m1, input int m2, input int idx,
                              input int sgn, input int deg, input int ovf);
        exp_q.push_back(pack(m1, m2, idx, sgn, deg, ovf));
        issued++;
    endtask

    // Drive one beat; called just after a rising edge, returns just after the accepting edge.
    task automatic beat(input int mag, input bit sgn, input bit last);
        int budget;
        in_valid = 1'b1;
        in_mag   = DATA_W'(mag);
        in_sign  = sgn;
        in_last  = last;
        budget   = 0;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL beat_accept: in_ready stuck low, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            received++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: min1=%0d idx=%0d deg=%0d, expected none",
                         out_min1, out_idx, out_deg);
            end else begin
                chk("row_result", 64'({out_min1, out_min2, out_idx, out_sign, out_deg, out_ovf}),
                    64'(exp_q.pop_front()));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
        chk({tag, "_min1"},      64'(out_min1),  64'(0));
        chk({tag, "_min2"},      64'(out_min2),  64'(0));
        chk({tag, "_idx_sign"},  64'({out_idx, out_sign}), 64'(0));
        chk({tag, "_deg_ovf"},   64'({out_deg, out_ovf}),  64'(0));
    endtask

    initial begin
        int budget;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        idle_cycle();

        // tie rule: the second 3 never displaces idx 1
        expect_row(3, 3, 1, 1, 4, 0);
        beat(7, 1, 0); beat(3, 0, 0); beat(5, 1, 0); beat(3, 1, 1);
        chk("latency_valid", 64'(out_valid), 64'(1));

        // back-to-back degree-1 row taken from HOLD
        expect_row(12, 511, 0, 1, 1, 0);
        beat(12, 1, 1);
        chk("deg1_valid", 64'(out_valid), 64'(1));
        idle_cycle();

        // overflow at DEG_MAX without in_last
        expect_row(2, 3, 7, 1, 8, 1);
        for (int m = 9; m >= 2; m--) beat(m, (m >= 7), 0);
        chk("ovf_hold", 64'(out_valid), 64'(1));
        idle_cycle();

        // stall: result pending, out_ready low, new beat waiting
        expect_row(2, 6, 1, 1, 2, 0);
        beat(6, 0, 0); beat(2, 1, 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mag    = 9'd10;
        in_sign   = 1'b0;
        in_last   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_outputs", 64'({out_valid, out_min1, out_min2, out_idx, out_deg}),
                64'({1'b1, 9'd2, 9'd6, 3'd1, 4'd2}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_row(10, 15, 0, 1, 3, 0);
        @(posedge clk);
        #1;
        chk("stall_release_acc", 64'(out_valid), 64'(0));
        beat(15, 1, 0); beat(20, 0, 1);
        idle_cycle();

        // flush drops the concurrent beat and the partial row
        beat(1, 0, 0); beat(2, 0, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_mag   = 9'd0;
        in_sign  = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        expect_row(5, 8, 1, 1, 2, 0);
        beat(8, 1, 0); beat(5, 0, 1);
        idle_cycle();

        // asynchronous reset between edges, mid-row
        beat(3, 0, 0); beat(1, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        expect_row(1, 4, 1, 0, 2, 0);
        beat(4, 0, 0); beat(1, 0, 1);

        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            budget++;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("all_rows_received", 64'(received), 64'(issued));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
